// File: rtl/history_ctrl.sv
// history_ctrl: LZS decode history sequencer. Expands literal/copy tokens into an output
// byte stream and mirrors every byte into the history RAM. Option: HISTORY_CTRL_OFFSET_CHK_EN.
module history_ctrl #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hist_clr,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic              tok_copy,
  input  logic [7:0]        tok_literal,
  input  logic [ADDR_W-1:0] tok_offset,
  input  logic [LEN_W-1:0]  tok_length,
  output logic [ADDR_W-1:0] ram_read_address,
  input  logic [7:0]        ram_read_data,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [7:0]        ram_write_data,
  output logic              ram_write_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              offset_err
);

  typedef enum logic [1:0] {IDLE, LIT, COPY} state_t;

  localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic              run;
  logic [ADDR_W-1:0] wr_ptr, wr_base, rd_ptr, rd_addr;
  logic [ADDR_W:0]   fill, fill_base;
  logic [LEN_W-1:0]  remaining;
  logic [7:0]        lit_q, byp_data;
  logic              byp_valid, clr_now, accept, write_now, bad_offset, copy_go;

  // A clear in IDLE takes effect before any token accepted in the same cycle.
  always_comb begin
    clr_now   = (state == IDLE) && hist_clr;
    wr_base   = clr_now ? '0 : wr_ptr;
    fill_base = clr_now ? '0 : fill;
  end

`ifdef HISTORY_CTRL_OFFSET_CHK_EN
  assign bad_offset = (tok_offset == '0) || ({1'b0, tok_offset} > fill_base);
`else
  assign bad_offset = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    rd_addr   = rd_ptr;
    tok_ready = (state == IDLE) && run;
    out_valid = 1'b0;
    out_data  = '0;
    accept    = tok_valid && tok_ready;
    copy_go   = accept && tok_copy && (tok_length != '0) && !bad_offset;
    case (state)
      IDLE: begin
        rd_addr = tok_ready ? (wr_base - tok_offset) : '0;
        if (accept && !tok_copy) state_nxt = LIT;
        else if (copy_go)        state_nxt = COPY;
      end
      LIT: begin
        out_valid = 1'b1;
        out_data  = lit_q;
        if (out_ready) state_nxt = IDLE;
      end
      COPY: begin
        // Overlapping copies read back a byte written the cycle before; bypass covers it.
        out_valid = 1'b1;
        out_data  = byp_valid ? byp_data : ram_read_data;
        if (out_ready) begin
          rd_addr = rd_ptr + ADDR_W'(1);
          if (remaining == LEN_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    write_now = out_valid && out_ready;
  end

  assign ram_read_address  = rd_addr;
  assign ram_write_address = wr_ptr;
  assign ram_write_data    = out_data;
  assign ram_write_valid   = write_now;
  assign busy              = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run       <= 1'b0;
      wr_ptr    <= '0;
      fill      <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
      lit_q     <= '0;
      byp_valid <= 1'b0;
      byp_data  <= '0;
    end else begin
      state     <= state_nxt;
      run       <= 1'b1;
      wr_ptr    <= wr_base + ADDR_W'(write_now);
      if (write_now && (fill != FILL_MAX)) fill <= fill + (ADDR_W+1)'(1);
      else                                 fill <= fill_base;
      if (copy_go)                          remaining <= tok_length;
      else if (state == COPY && write_now)  remaining <= remaining - LEN_W'(1);
      if (accept && !tok_copy) lit_q <= tok_literal;
      rd_ptr    <= rd_addr;
      byp_valid <= write_now && (rd_addr == wr_ptr);
      byp_data  <= out_data;
    end
  end

`ifdef HISTORY_CTRL_OFFSET_CHK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err_q <= 1'b0;
    else if (accept && tok_copy && bad_offset) err_q <= 1'b1;
    else if (clr_now)                         err_q <= 1'b0;
  end

  assign offset_err = err_q;
`else
  assign offset_err = 1'b0;
`endif

endmodule
